// File: rtl/serial_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_comparator
// Purpose  : Bit-serial magnitude comparator (G/L/EQ) with start/bit_valid/done
//            framing. Define SERIAL_COMP_MSB_FIRST_EN for MSB-first operands.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             x_bit,
    input  logic             y_bit,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             G,
    output logic             L,
    output logic             EQ,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0] r_state;
    logic       w_take;

`ifdef SERIAL_COMP_MSB_FIRST_EN
    // First differing bit is the most significant one; later bits cannot override it.
    assign w_take = (x_bit ^ y_bit) & ~(G | L);
`else
    // Later bits are more significant, so every difference overwrites the verdict.
    assign w_take = x_bit ^ y_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            G            <= 1'b0;
            L            <= 1'b0;
            bit_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_SHIFT;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        G            <= 1'b0;
                        L            <= 1'b0;
                        bit_cnt      <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (w_take) begin
                            G <= x_bit;
                            L <= y_bit;
                        end
                        if (bit_cnt == C_LAST_BIT) begin
                            r_state      <= ST_DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            result_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign EQ = result_valid & ~G & ~L;

endmodule
`default_nettype wire
